// File: rtl/toe_pkg.sv
// Shared types and register map for the TOE connection CSR block.
package toe_pkg;

   // Per-channel connection lifecycle
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      ACTIVE  = 2'd2,
      DONE    = 2'd3
   } ch_state_t;

   // Word offsets inside one channel's register window
   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_STATUS  = 3'd1;
   localparam logic [2:0] REG_IP_SRC  = 3'd2;
   localparam logic [2:0] REG_IP_DST  = 3'd3;
   localparam logic [2:0] REG_SRC_HI  = 3'd4;
   localparam logic [2:0] REG_SRC_LO  = 3'd5;
   localparam logic [2:0] REG_DST_HI  = 3'd6;
   localparam logic [2:0] REG_DST_LO  = 3'd7;

   // CTRL command bits
   localparam int CTRL_OPEN_BIT   = 30;
   localparam int CTRL_ERRCLR_BIT = 29;

   // STATUS field positions
   localparam int STATUS_DONE_BIT = 31;
   localparam int STATUS_CODE_LSB = 16;
   localparam int STATUS_ERR_BIT  = 8;

   // Assemble the software-visible STATUS word for one channel
   function automatic logic [31:0] status_word(input ch_state_t st,
                                               input logic      err,
                                               input logic [7:0] code);
      logic [31:0] w;
      w = '0;
      w[STATUS_DONE_BIT]        = (st == DONE);
      w[STATUS_CODE_LSB +: 8]   = code;
      w[STATUS_ERR_BIT]         = err;
      w[1:0]                    = st;
      return w;
   endfunction

endpackage

// File: rtl/toe_idx_fifo.sv
// In-order queue of channel indexes waiting to be offered to the TOE core.
module toe_idx_fifo
   import toe_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra MSB so full and empty differ only by the wrap flag
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A full queue refuses a push even when a pop frees a slot in the same cycle
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   // Storage and pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         // NOTE: storage is cleared too, so dout (and the descriptor mux it drives) is 0 out of reset rather than X.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values, independent of statement order.
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
            wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/toe_conn_csr.sv
// Avalon-MM CSR front-end: per-channel connection descriptors, open-request
// queue towards the TOE core, and completion status / interrupt reporting.
module toe_conn_csr
   import toe_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CH_W       = $clog2(NUM_CH),
   parameter int ADDR_W     = CH_W + 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [CH_W-1:0]   req_ch,
   output logic [31:0]       req_ip_src,
   output logic [31:0]       req_ip_dst,
   output logic [47:0]       req_mac_src,
   output logic [47:0]       req_mac_dst,
   output logic [15:0]       req_port_src,
   output logic [15:0]       req_port_dst,
   input  logic              done_valid,
   input  logic [CH_W-1:0]   done_ch,
   input  logic [7:0]        done_code,
   output logic              irq
);

   // Per-channel state and descriptors
   ch_state_t   state_q    [NUM_CH];
   ch_state_t   state_d    [NUM_CH];
   logic [NUM_CH-1:0] err_q;
   logic [NUM_CH-1:0] err_d;
   logic [7:0]  code_q     [NUM_CH];
   logic [7:0]  code_d     [NUM_CH];
   logic [31:0] ip_src_q   [NUM_CH];
   logic [31:0] ip_src_d   [NUM_CH];
   logic [31:0] ip_dst_q   [NUM_CH];
   logic [31:0] ip_dst_d   [NUM_CH];
   logic [47:0] mac_src_q  [NUM_CH];
   logic [47:0] mac_src_d  [NUM_CH];
   logic [47:0] mac_dst_q  [NUM_CH];
   logic [47:0] mac_dst_d  [NUM_CH];
   logic [15:0] port_src_q [NUM_CH];
   logic [15:0] port_src_d [NUM_CH];
   logic [15:0] port_dst_q [NUM_CH];
   logic [15:0] port_dst_d [NUM_CH];

   logic [31:0] readdata_q;
   logic [31:0] readdata_d;
   logic        irq_q;
   logic        irq_d;

   // Bus decode
   logic            wr_en;
   logic            rd_en;
   logic [CH_W-1:0] acc_ch;
   logic [2:0]      acc_reg;
   logic            desc_locked;
   logic            open_req;

   // Request queue
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CH_W-1:0] head_ch;

   assign wr_en    = chipselect && write;
   assign rd_en    = chipselect && read;
   assign acc_ch   = address[ADDR_W-1:3];
   assign acc_reg  = address[2:0];

   // Descriptors are frozen while the core may be looking at them
   assign desc_locked = (state_q[acc_ch] == PENDING) || (state_q[acc_ch] == ACTIVE);

   assign open_req = wr_en && (acc_reg == REG_CTRL) && writedata[CTRL_OPEN_BIT];
   assign push     = open_req && (state_q[acc_ch] == IDLE) && !fifo_full;
   assign pop      = req_valid && req_ready;

   toe_idx_fifo #(
      .WIDTH (CH_W),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (acc_ch),
      .dout  (head_ch),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head-of-queue channel's descriptor is presented directly; it cannot change while PENDING
   assign req_valid    = !fifo_empty;
   assign req_ch       = head_ch;
   assign req_ip_src   = ip_src_q[head_ch];
   assign req_ip_dst   = ip_dst_q[head_ch];
   assign req_mac_src  = mac_src_q[head_ch];
   assign req_mac_dst  = mac_dst_q[head_ch];
   assign req_port_src = port_src_q[head_ch];
   assign req_port_dst = port_dst_q[head_ch];

   assign readdata = readdata_q;
   assign irq      = irq_q;

   // Channel next-state: core handshake, completion, then software write, then error clear
   always_comb begin
      // NOTE: every _d starts as its _q so no path through the branches below leaves a value unassigned (no latches).
      state_d    = state_q;
      err_d      = err_q;
      code_d     = code_q;
      ip_src_d   = ip_src_q;
      ip_dst_d   = ip_dst_q;
      mac_src_d  = mac_src_q;
      mac_dst_d  = mac_dst_q;
      port_src_d = port_src_q;
      port_dst_d = port_dst_q;
      irq_d      = 1'b0;

      for (int i = 0; i < NUM_CH; i++) begin
         if (pop && (head_ch == CH_W'(i))) begin
            state_d[i] = ACTIVE;
         end

         if (done_valid && (done_ch == CH_W'(i))) begin
            if (state_q[i] == ACTIVE) begin
               state_d[i] = DONE;
               code_d[i]  = done_code;
            end else begin
               err_d[i] = 1'b1;
            end
         end

         if (wr_en && (acc_ch == CH_W'(i))) begin
            case (acc_reg)
               REG_CTRL: begin
                  if (writedata[CTRL_OPEN_BIT]) begin
                     if (push) begin
                        state_d[i] = PENDING;
                     end else begin
                        err_d[i] = 1'b1;
                     end
                  end else if (state_q[i] == DONE) begin
                     state_d[i] = IDLE;
                     code_d[i]  = 8'h00;
                  end
               end
               REG_STATUS: begin
                  // read-only
               end
               REG_IP_SRC: begin
                  if (desc_locked) err_d[i] = 1'b1;
                  else             ip_src_d[i] = writedata;
               end
               REG_IP_DST: begin
                  if (desc_locked) err_d[i] = 1'b1;
                  else             ip_dst_d[i] = writedata;
               end
               REG_SRC_HI: begin
                  if (desc_locked) err_d[i] = 1'b1;
                  else             mac_src_d[i][47:16] = writedata;
               end
               REG_SRC_LO: begin
                  if (desc_locked) err_d[i] = 1'b1;
                  else begin
                     mac_src_d[i][15:0] = writedata[31:16];
                     port_src_d[i]      = writedata[15:0];
                  end
               end
               REG_DST_HI: begin
                  if (desc_locked) err_d[i] = 1'b1;
                  else             mac_dst_d[i][47:16] = writedata;
               end
               REG_DST_LO: begin
                  if (desc_locked) err_d[i] = 1'b1;
                  else begin
                     mac_dst_d[i][15:0] = writedata[31:16];
                     port_dst_d[i]      = writedata[15:0];
                  end
               end
               default: begin
               end
            endcase

            // Error clear wins over any error raised in the same cycle
            if ((acc_reg == REG_CTRL) && writedata[CTRL_ERRCLR_BIT]) begin
               err_d[i] = 1'b0;
            end
         end

         irq_d = irq_d | (state_d[i] == DONE);
      end
   end

   // Read mux; data appears one cycle after the read strobe and is 0 otherwise
   always_comb begin
      readdata_d = '0;
      if (rd_en) begin
         case (acc_reg)
            REG_STATUS: readdata_d = status_word(state_q[acc_ch], err_q[acc_ch], code_q[acc_ch]);
            REG_IP_SRC: readdata_d = ip_src_q[acc_ch];
            REG_IP_DST: readdata_d = ip_dst_q[acc_ch];
            REG_SRC_HI: readdata_d = mac_src_q[acc_ch][47:16];
            REG_SRC_LO: readdata_d = {mac_src_q[acc_ch][15:0], port_src_q[acc_ch]};
            REG_DST_HI: readdata_d = mac_dst_q[acc_ch][47:16];
            REG_DST_LO: readdata_d = {mac_dst_q[acc_ch][15:0], port_dst_q[acc_ch]};
            default:    readdata_d = '0;
         endcase
      end
   end

   // State, descriptor, read-data and interrupt registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]    <= IDLE;
            code_q[i]     <= '0;
            ip_src_q[i]   <= '0;
            ip_dst_q[i]   <= '0;
            mac_src_q[i]  <= '0;
            mac_dst_q[i]  <= '0;
            port_src_q[i] <= '0;
            port_dst_q[i] <= '0;
         end
         err_q      <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         code_q     <= code_d;
         ip_src_q   <= ip_src_d;
         ip_dst_q   <= ip_dst_d;
         mac_src_q  <= mac_src_d;
         mac_dst_q  <= mac_dst_d;
         port_src_q <= port_src_d;
         port_dst_q <= port_dst_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

endmodule

// File: tb/tb_toe_conn_csr.sv
// Scoreboard bench for toe_conn_csr: stimulus queues expected read data and
// expected core requests; a monitor compares them as the DUT presents them.
module tb_toe_conn_csr;
   import toe_pkg::*;

   localparam int NUM_CH     = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int CH_W       = 2;
   localparam int ADDR_W     = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              chipselect = 1'b0;
   logic              read = 1'b0;
   logic              write = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [31:0]       writedata = '0;
   logic [31:0]       readdata;
   logic              req_valid;
   logic              req_ready = 1'b0;
   logic [CH_W-1:0]   req_ch;
   logic [31:0]       req_ip_src;
   logic [31:0]       req_ip_dst;
   logic [47:0]       req_mac_src;
   logic [47:0]       req_mac_dst;
   logic [15:0]       req_port_src;
   logic [15:0]       req_port_dst;
   logic              done_valid = 1'b0;
   logic [CH_W-1:0]   done_ch = '0;
   logic [7:0]        done_code = '0;
   logic              irq;

   toe_conn_csr #(
      .NUM_CH     (NUM_CH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .chipselect   (chipselect),
      .read         (read),
      .write        (write),
      .address      (address),
      .writedata    (writedata),
      .readdata     (readdata),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_ch       (req_ch),
      .req_ip_src   (req_ip_src),
      .req_ip_dst   (req_ip_dst),
      .req_mac_src  (req_mac_src),
      .req_mac_dst  (req_mac_dst),
      .req_port_src (req_port_src),
      .req_port_dst (req_port_dst),
      .done_valid   (done_valid),
      .done_ch      (done_ch),
      .done_code    (done_code),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [31:0]     ip_src;
      logic [31:0]     ip_dst;
      logic [47:0]     mac_src;
      logic [47:0]     mac_dst;
      logic [15:0]     port_src;
      logic [15:0]     port_dst;
   } req_t;

   req_t        req_exp_q [$];
   logic [31:0] rd_exp_q  [$];
   string       rd_name_q [$];

   int n_tests = 0;
   int n_fail  = 0;

   logic rd_seen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Remember which cycles carried a read so the monitor knows readdata is a response
   always @(posedge clk or posedge rst) begin
      if (rst) rd_seen <= 1'b0;
      else     rd_seen <= chipselect & read;
   end

   // Monitor: sample after the falling edge, when stimulus has settled
   initial begin : monitor
      logic [31:0] exp_rd;
      string       nm;
      req_t        r;
      forever begin
         @(negedge clk);
         #1;
         if (rd_seen) begin
            if (rd_exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_read: got 0x%0h with no expected value queued", readdata);
            end else begin
               exp_rd = rd_exp_q.pop_front();
               nm     = rd_name_q.pop_front();
               check(nm, 64'(readdata), 64'(exp_rd));
            end
         end
         if (req_valid && req_ready) begin
            if (req_exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_req: got req_ch %0d with no request queued", req_ch);
            end else begin
               r = req_exp_q.pop_front();
               check("req_ch",       64'(req_ch),       64'(r.ch));
               check("req_ip_src",   64'(req_ip_src),   64'(r.ip_src));
               check("req_ip_dst",   64'(req_ip_dst),   64'(r.ip_dst));
               check("req_mac_src",  64'(req_mac_src),  64'(r.mac_src));
               check("req_mac_dst",  64'(req_mac_dst),  64'(r.mac_dst));
               check("req_port_src", 64'(req_port_src), 64'(r.port_src));
               check("req_port_dst", 64'(req_port_dst), 64'(r.port_dst));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input int ch, input logic [2:0] r, input logic [31:0] d);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = {CH_W'(ch), r};
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic bus_rd(input int ch, input logic [2:0] r, input logic [31:0] exp, input string nm);
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(nm);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = {CH_W'(ch), r};
      @(negedge clk);
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   task automatic pulse_done(input int ch, input logic [7:0] code);
      done_valid = 1'b1;
      done_ch    = CH_W'(ch);
      done_code  = code;
      @(negedge clk);
      done_valid = 1'b0;
   endtask

   // Watchdog so the bench always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      req_t r;

      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_irq",       64'(irq),       64'd0);
      check("rst_readdata",  64'(readdata),  64'd0);

      // Put ch0 in PENDING with a descriptor, then reset asynchronously mid-cycle
      bus_wr(0, REG_IP_SRC, 32'h1234_5678);
      bus_wr(0, REG_CTRL,   32'h4000_0000);
      bus_rd(0, REG_STATUS, 32'h0000_0001, "ch0_pending_status");
      check("pending_req_valid", 64'(req_valid), 64'd1);
      #2 rst = 1'b1;
      #1 check("async_rst_req_valid", 64'(req_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
         bus_rd(c, REG_STATUS, 32'h0, "post_rst_status");
      end
      bus_rd(0, REG_IP_SRC, 32'h0, "post_rst_ch0_ip_src");
      @(negedge clk);
      check("readdata_zero_without_read", 64'(readdata), 64'd0);
      check("post_rst_irq",       64'(irq),       64'd0);
      check("post_rst_req_valid", 64'(req_valid), 64'd0);

      // Program ch1 and open it with the core ready
      bus_wr(1, REG_IP_SRC, 32'h1111_1111);
      bus_wr(1, REG_IP_DST, 32'h2222_2222);
      bus_wr(1, REG_SRC_HI, 32'h3333_3333);
      bus_wr(1, REG_SRC_LO, 32'h3333_5555);
      bus_wr(1, REG_DST_HI, 32'h4444_4444);
      bus_wr(1, REG_DST_LO, 32'h4444_6666);
      r = '{ch: 2'd1, ip_src: 32'h1111_1111, ip_dst: 32'h2222_2222,
            mac_src: 48'h3333_3333_3333, mac_dst: 48'h4444_4444_4444,
            port_src: 16'h5555, port_dst: 16'h6666};
      req_exp_q.push_back(r);
      req_ready = 1'b1;
      bus_wr(1, REG_CTRL, 32'h4000_0000);
      idle(2);
      bus_rd(1, REG_STATUS, 32'h0000_0002, "ch1_active_status");
      req_ready = 1'b0;
      bus_rd(1, REG_IP_DST, 32'h2222_2222, "ch1_ip_dst_readback");
      bus_rd(1, REG_SRC_LO, 32'h3333_5555, "ch1_src_lo_readback");
      bus_rd(1, REG_DST_LO, 32'h4444_6666, "ch1_dst_lo_readback");

      // Completion and clear on ch1
      pulse_done(1, 8'h5A);
      check("done_irq", 64'(irq), 64'd1);
      bus_rd(1, REG_STATUS, 32'h805A_0003, "ch1_done_status");
      bus_wr(1, REG_CTRL, 32'h0000_0000);
      check("clear_irq", 64'(irq), 64'd0);
      bus_rd(1, REG_STATUS, 32'h0000_0000, "ch1_cleared_status");

      // Completion for an idle channel only raises err
      pulse_done(3, 8'h77);
      bus_rd(3, REG_STATUS, 32'h0000_0100, "ch3_spurious_done_status");
      bus_wr(3, REG_CTRL, 32'h2000_0000);
      bus_rd(3, REG_STATUS, 32'h0000_0000, "ch3_errclr_status");

      // Fill the queue with the core stalled
      bus_wr(2, REG_IP_SRC, 32'hCAFE_0002);
      r = '{ch: 2'd0, ip_src: 32'h0, ip_dst: 32'h0, mac_src: 48'h0, mac_dst: 48'h0,
            port_src: 16'h0, port_dst: 16'h0};
      req_exp_q.push_back(r);
      r = '{ch: 2'd1, ip_src: 32'h1111_1111, ip_dst: 32'h2222_2222,
            mac_src: 48'h3333_3333_3333, mac_dst: 48'h4444_4444_4444,
            port_src: 16'h5555, port_dst: 16'h6666};
      req_exp_q.push_back(r);
      r = '{ch: 2'd2, ip_src: 32'hCAFE_0002, ip_dst: 32'h0, mac_src: 48'h0, mac_dst: 48'h0,
            port_src: 16'h0, port_dst: 16'h0};
      req_exp_q.push_back(r);
      r = '{ch: 2'd3, ip_src: 32'h0, ip_dst: 32'h0, mac_src: 48'h0, mac_dst: 48'h0,
            port_src: 16'h0, port_dst: 16'h0};
      req_exp_q.push_back(r);
      for (int c = 0; c < NUM_CH; c++) begin
         bus_wr(c, REG_CTRL, 32'h4000_0000);
      end
      check("full_req_valid", 64'(req_valid), 64'd1);
      check("full_req_ch",    64'(req_ch),    64'd0);
      bus_wr(0, REG_CTRL, 32'h4000_0000);
      bus_rd(0, REG_STATUS, 32'h0000_0101, "ch0_reopen_err_status");

      // Descriptor write on a pending channel is dropped
      bus_wr(2, REG_IP_SRC, 32'hDEAD_BEEF);
      bus_rd(2, REG_IP_SRC, 32'hCAFE_0002, "ch2_locked_ip_src");
      bus_rd(2, REG_STATUS, 32'h0000_0101, "ch2_locked_err_status");
      bus_wr(2, REG_CTRL, 32'h2000_0000);
      bus_rd(2, REG_STATUS, 32'h0000_0001, "ch2_errclr_status");

      // Release the core; requests must come out 0,1,2,3
      req_ready = 1'b1;
      idle(6);
      req_ready = 1'b0;
      check("req_queue_drained", 64'(req_exp_q.size()), 64'd0);
      check("drained_req_valid", 64'(req_valid), 64'd0);
      bus_rd(3, REG_STATUS, 32'h0000_0002, "ch3_active_status");
      bus_rd(0, REG_STATUS, 32'h0000_0102, "ch0_active_err_status");

      // Complete ch2, then an OPEN on a DONE channel is refused
      pulse_done(2, 8'hC3);
      check("ch2_done_irq", 64'(irq), 64'd1);
      bus_rd(2, REG_STATUS, 32'h80C3_0003, "ch2_done_status");
      bus_wr(2, REG_CTRL, 32'h4000_0000);
      bus_rd(2, REG_STATUS, 32'h80C3_0103, "ch2_open_on_done_status");
      check("open_on_done_req_valid", 64'(req_valid), 64'd0);

      idle(2);
      check("rd_queue_drained", 64'(rd_exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/toe_conn_csr.md
Name: toe_conn_csr

Overview:
Multi-channel Avalon-MM control/status front-end for the TOE core. Software programs up to NUM_CH connection descriptors (IP/MAC/port tuples), then writes an open request per channel. Requests are queued in order and handed to the TOE core over a valid/ready interface. Completions from the core are posted back into per-channel status words.

Parameters:
NUM_CH, 4, number of connection channels (power of 2, >=2)
FIFO_DEPTH, 4, request queue depth (power of 2, >=2)
CH_W, $clog2(NUM_CH), channel index width (derived)
ADDR_W, CH_W+3, Avalon word address width (derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
chipselect  in  1  Avalon slave select
read  in  1  Avalon read strobe
write  in  1  Avalon write strobe
address  in  ADDR_W  {channel[CH_W-1:0], reg[2:0]}
writedata  in  32  write data
readdata  out  32  registered read data
req_valid  out  1  request to core valid
req_ready  in  1  core accepts request
req_ch  out  CH_W  channel of offered request
req_ip_src, req_ip_dst  out  32 each  descriptor IPs
req_mac_src, req_mac_dst  out  48 each  descriptor MACs
req_port_src, req_port_dst  out  16 each  descriptor ports
done_valid  in  1  single-cycle completion pulse from core
done_ch  in  CH_W  completing channel
done_code  in  8  completion result code
irq  out  1  OR of all channel DONE flags

Behaviour:
- Clock clk; reset rst asynchronous, active-high; all state cleared on assertion, including mid-transaction.
- Reset values: readdata=0, req_valid=0, irq=0, all descriptors 0, all channels IDLE, FIFO empty, err bits 0.
- Per-channel regs: 0 CTRL(W), 1 STATUS(R), 2 IP_SRC, 3 IP_DST, 4 MAC_SRC[47:16], 5 {MAC_SRC[15:0],PORT_SRC}, 6 MAC_DST[47:16], 7 {MAC_DST[15:0],PORT_DST}. Regs 2-7 read back as written.
- Write takes effect on the clk edge where chipselect&write. Read: readdata registered one cycle after chipselect&read; 0 on cycles without a read.
- Channel FSM (2-bit): IDLE=0, PENDING=1, ACTIVE=2, DONE=3.
- CTRL bit30=1 (OPEN): IDLE and FIFO not full -> PENDING, push channel index. Otherwise (not IDLE, or FIFO full) -> no change, set channel err.
- CTRL bit30=0 (CLEAR): DONE -> IDLE, done_code cleared. Ignored in other states. CTRL bit29=1 clears err (same cycle as OPEN: clear wins over a new err set).
- Descriptor writes (regs 2-7) while PENDING or ACTIVE are dropped and set err.
- STATUS = {31:DONE flag, 30:24 zero, 23:16 done_code, 15:9 zero, 8:err, 7:2 zero, 1:0 state}.
- req_valid = FIFO not empty; req_ch = head index; req_* fields combinationally selected from that channel's descriptor (stable, channel is locked). Handshake: req_valid&req_ready pops head, channel PENDING->ACTIVE. req_valid never drops without acceptance.
- done_valid with done_ch ACTIVE -> DONE, latch done_code. done_valid for non-ACTIVE channel: ignored, sets err on done_ch.
- FIFO push and pop in same cycle: both happen, count unchanged; push at full is refused even if popping that cycle (software-visible rule: full means refuse).
- OPEN write and pop/done on different channels in same cycle: all independent. Same-channel conflicts are impossible by state.
- irq = |(state==DONE) over channels, registered.
- Pointer wrap: FIFO pointers CH-independent, $clog2(FIFO_DEPTH)+1 bits with MSB wrap flag.

Decomposition:
- Package toe_pkg: ch_state_t enum (IDLE/PENDING/ACTIVE/DONE), register offset localparams (REG_CTRL..REG_DST_LO), CTRL bit positions (OPEN=30, ERRCLR=29), STATUS field positions.
- Sub-module toe_idx_fifo: synchronous FIFO of CH_W-bit indexes, params WIDTH/DEPTH, ports push/pop/din/dout/full/empty.

Test Plan:
- Reset mid-PENDING on ch0 -> all STATUS read 0x0000_0000, req_valid=0, irq=0.
- Program ch1: IP_SRC=0x11111111, IP_DST=0x22222222, reg4=0x33333333, reg5=0x3333_5555, reg6=0x44444444, reg7=0x4444_6666; CTRL=0x4000_0000; req_ready=1 -> req_ch=1, req_mac_src=0x333333333333, req_port_dst=0x6666; STATUS=0x0000_0002.
- done_valid, done_ch=1, done_code=0x5A -> STATUS=0x805A_0003, irq=1; CTRL=0 -> STATUS=0, irq=0.
- req_ready=0, OPEN ch0..ch3 then ch0 again (FIFO_DEPTH=4) -> fifth OPEN sets err (STATUS bit8); release ready -> pops in order 0,1,2,3.
- Write IP_SRC=0xDEADBEEF on PENDING ch2 -> readback unchanged, err=1; CTRL=0x2000_0000 -> err=0.
- done_valid for IDLE ch3 -> no state change, ch3 STATUS=0x0000_0100.
